incoming_ctx_sequencer: RTL and testbench

Pipelined sequencer for the per-flow user-context path of the incoming-ACK datapath. Accepts incoming events and context-init requests, reads the flow's user context from an internal context array, and presents it with the event payload to the combinational `user_defined_incoming` logic. It captures the updated context in the same cycle and writes it back. Full throughput (one op/cycle) is required, including back-to-back ops on the same flow, so read-after-write hazards are resolved by forwarding.

---
 rtl/incoming_ctx_sequencer.sv | 175 +++++++++++++++++
 tb/tb_incoming_ctx_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/incoming_ctx_sequencer.sv
// Two-stage sequencer for the per-flow user context of the incoming-ACK path.
// Stage A accepts an event or an init and addresses the context array.
// Stage B presents the context to the external compute logic and writes the
// result back.
// A one-entry forward register covers the case where the read in stage A
// misses the write that stage B commits at the same edge.
//
// Handshake: an op is accepted at a rising edge when valid & ready are both
// high at that edge. ready never depends on valid of the same channel. The
// requester holds its payload stable until acceptance. Init has strict
// priority, so ev_ready drops whenever init_valid is high.

`ifndef USER_CONTEXT_W
`define USER_CONTEXT_W 64
`endif

module incoming_ctx_sequencer #(
  parameter int FLOW_ID_W = 8,
  parameter int CTX_W     = `USER_CONTEXT_W,
  parameter int EV_W      = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ev_valid,
  output logic                 ev_ready,
  input  logic [FLOW_ID_W-1:0] ev_flow_id,
  input  logic [EV_W-1:0]      ev_data,
  input  logic                 init_valid,
  output logic                 init_ready,
  input  logic [FLOW_ID_W-1:0] init_flow_id,
  input  logic [CTX_W-1:0]     init_ctx,
  output logic                 cmp_valid,
  output logic [FLOW_ID_W-1:0] cmp_flow_id,
  output logic [EV_W-1:0]      cmp_ev_data,
  output logic [CTX_W-1:0]     cmp_ctx_in,
  input  logic [CTX_W-1:0]     cmp_ctx_out,
  output logic [31:0]          ev_done_cnt
);

  localparam int DEPTH = 1 << FLOW_ID_W;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [FLOW_ID_W-1:0] clr_idx, clr_idx_nxt;
  logic                 clr_we;

  logic [CTX_W-1:0]     ctx_mem [DEPTH];
  logic [CTX_W-1:0]     rd_data;

  logic                 acc_ev, acc_init, acc_any;
  logic [FLOW_ID_W-1:0] a_flow;

  logic                 b_valid;
  logic                 b_is_ev;
  logic [FLOW_ID_W-1:0] b_flow;
  logic [CTX_W-1:0]     b_init_ctx;
  logic [CTX_W-1:0]     b_wdata;
  logic [CTX_W-1:0]     b_ctx;
  logic                 b_we;

  logic                 fwd_hit;
  logic [CTX_W-1:0]     fwd_data;
  logic [CTX_W-1:0]     ctx_hold;

  logic                 mem_we;
  logic [FLOW_ID_W-1:0] mem_waddr;
  logic [CTX_W-1:0]     mem_wdata;

  // State register: CLEAR sweep after reset, then RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  // Next state, clear sweep and handshake readiness.
  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    clr_we      = 1'b0;
    ev_ready    = 1'b0;
    init_ready  = 1'b0;
    case (state)
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_idx == '1) begin
          state_nxt   = RUN;
          clr_idx_nxt = '0;
        end else begin
          clr_idx_nxt = clr_idx + 1'b1;
        end
      end
      RUN: begin
        init_ready = 1'b1;
        ev_ready   = ~init_valid;
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  assign acc_init = init_valid & init_ready;
  assign acc_ev   = ev_valid & ev_ready;
  assign acc_any  = acc_init | acc_ev;
  assign a_flow   = acc_init ? init_flow_id : ev_flow_id;

  // The stage-B write value is either the compute result or the init value.
  assign b_wdata  = b_is_ev ? cmp_ctx_out : b_init_ctx;
  assign b_ctx    = fwd_hit ? fwd_data : rd_data;
  assign b_we     = b_valid & ~rst;

  // Only one writer is ever active: CLEAR sweeps, RUN writes back stage B.
  assign mem_we    = (clr_we & ~rst) | b_we;
  assign mem_waddr = clr_we ? clr_idx : b_flow;
  assign mem_wdata = clr_we ? '0 : b_wdata;

  // Context array: one write port, registered read-first read port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      ctx_mem[mem_waddr] <= mem_wdata;
    end
    if (acc_any) begin
      rd_data <= ctx_mem[a_flow];
    end
  end

  // Pipeline registers for stage B, forward capture and the done counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_valid     <= 1'b0;
      b_is_ev     <= 1'b0;
      b_flow      <= '0;
      b_init_ctx  <= '0;
      fwd_hit     <= 1'b0;
      fwd_data    <= '0;
      cmp_flow_id <= '0;
      cmp_ev_data <= '0;
      ctx_hold    <= '0;
      ev_done_cnt <= '0;
    end else begin
      b_valid <= acc_any;
      if (acc_any) begin
        b_is_ev    <= acc_ev;
        b_flow     <= a_flow;
        b_init_ctx <= init_ctx;
        // The array read issued at this edge cannot see the write landing at
        // the same edge, so remember that write if it targets the same flow.
        fwd_hit    <= b_valid && (b_flow == a_flow);
        fwd_data   <= b_wdata;
      end
      if (acc_ev) begin
        cmp_flow_id <= ev_flow_id;
        cmp_ev_data <= ev_data;
      end
      if (b_valid && b_is_ev) begin
        ctx_hold    <= b_ctx;
        ev_done_cnt <= ev_done_cnt + 32'd1;
      end
    end
  end

  // cmp_ctx_in keeps its last event value while no event is in stage B.
  assign cmp_valid  = b_valid & b_is_ev;
  assign cmp_ctx_in = cmp_valid ? b_ctx : ctx_hold;

endmodule

// File: tb/tb_incoming_ctx_sequencer.sv
// Bench for incoming_ctx_sequencer: directed scenarios plus random traffic.
// The reference model applies ops to a plain context array in acceptance
// order.
module tb_incoming_ctx_sequencer;

  localparam int FW    = 4;
  localparam int CW    = 16;
  localparam int EW    = 32;
  localparam int DEPTH = 16;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          ev_valid = 1'b0;
  logic          ev_ready;
  logic [FW-1:0] ev_flow_id = '0;
  logic [EW-1:0] ev_data = '0;
  logic          init_valid = 1'b0;
  logic          init_ready;
  logic [FW-1:0] init_flow_id = '0;
  logic [CW-1:0] init_ctx = '0;
  logic          cmp_valid;
  logic [FW-1:0] cmp_flow_id;
  logic [EW-1:0] cmp_ev_data;
  logic [CW-1:0] cmp_ctx_in;
  logic [CW-1:0] cmp_ctx_out;
  logic [31:0]   ev_done_cnt;

  int   checks = 0;
  int   errors = 0;
  logic f_mode = 1'b0;

  incoming_ctx_sequencer #(.FLOW_ID_W(FW), .CTX_W(CW), .EV_W(EW)) dut (
    .clk(clk), .rst(rst),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_flow_id(ev_flow_id), .ev_data(ev_data),
    .init_valid(init_valid), .init_ready(init_ready), .init_flow_id(init_flow_id),
    .init_ctx(init_ctx),
    .cmp_valid(cmp_valid), .cmp_flow_id(cmp_flow_id), .cmp_ev_data(cmp_ev_data),
    .cmp_ctx_in(cmp_ctx_in), .cmp_ctx_out(cmp_ctx_out), .ev_done_cnt(ev_done_cnt)
  );

  // Stand-in for the user compute logic.
  function automatic logic [CW-1:0] upd(input logic [CW-1:0] x, input logic [EW-1:0] d,
                                        input logic m);
    logic [CW-1:0] lo;
    lo = d[CW-1:0];
    return m ? (x * 16'd3 + lo) : (x + 16'd1);
  endfunction

  assign cmp_ctx_out = upd(cmp_ctx_in, cmp_ev_data, f_mode);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: context array, pending stage-B op, clear countdown.
  logic [CW-1:0] model [DEPTH];
  logic [CW-1:0] exp_q [$];
  int            clr_left = 16;
  logic          bm_valid = 1'b0;
  logic          bm_ev = 1'b0;
  logic [FW-1:0] bm_flow = '0;
  logic [EW-1:0] bm_data = '0;
  logic [CW-1:0] bm_init = '0;
  int unsigned   exp_done = 0;
  bit            started = 1'b0;

  always @(posedge clk) begin : model_step
    bit run_pre;
    started = 1'b1;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      exp_q.delete();
      clr_left = 16;
      bm_valid = 1'b0;
      exp_done = 0;
    end else begin
      run_pre = (clr_left == 0);
      if (clr_left > 0) clr_left--;
      if (bm_valid) begin
        if (bm_ev) begin
          model[bm_flow] = upd(model[bm_flow], bm_data, f_mode);
          exp_done++;
        end else begin
          model[bm_flow] = bm_init;
        end
      end
      bm_valid = 1'b0;
      if (run_pre && init_valid) begin
        bm_valid = 1'b1; bm_ev = 1'b0; bm_flow = init_flow_id; bm_init = init_ctx;
      end else if (run_pre && ev_valid) begin
        bm_valid = 1'b1; bm_ev = 1'b1; bm_flow = ev_flow_id; bm_data = ev_data;
        exp_q.push_back(model[ev_flow_id]);
      end
    end
  end

  // Scoreboard compare, every cycle on the falling edge.
  always @(negedge clk) begin : compare
    logic          run;
    logic [CW-1:0] e;
    if (started) begin
      run = (clr_left == 0);
      chk("ev_ready", ev_ready, run && !init_valid);
      chk("init_ready", init_ready, run);
      chk("cmp_valid", cmp_valid, bm_valid && bm_ev);
      if (bm_valid && bm_ev) begin
        if (exp_q.size() == 0) begin
          chk("exp_q_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("cmp_ctx_in", cmp_ctx_in, e);
          chk("cmp_flow_id", cmp_flow_id, bm_flow);
          chk("cmp_ev_data", cmp_ev_data, bm_data);
        end
      end
      chk("ev_done_cnt", ev_done_cnt, exp_done);
    end
  end

  // Driver tasks. send_ev leaves ev_valid high so calls can run back to back.
  task automatic send_ev(input logic [FW-1:0] f, input logic [EW-1:0] d);
    bit acc;
    acc = 1'b0;
    ev_valid = 1'b1; ev_flow_id = f; ev_data = d;
    for (int t = 0; t < 100 && !acc; t++) begin
      #1 acc = ev_ready;
      @(posedge clk); #1;
    end
    if (!acc) chk("ev_accept_timeout", 0, 1);
  endtask

  task automatic send_init(input logic [FW-1:0] f, input logic [CW-1:0] v);
    bit acc;
    acc = 1'b0;
    ev_valid = 1'b0;
    init_valid = 1'b1; init_flow_id = f; init_ctx = v;
    for (int t = 0; t < 100 && !acc; t++) begin
      #1 acc = init_ready;
      @(posedge clk); #1;
    end
    init_valid = 1'b0;
    if (!acc) chk("init_accept_timeout", 0, 1);
  endtask

  task automatic idle();
    ev_valid = 1'b0;
    init_valid = 1'b0;
  endtask

  task automatic wait_run(output int zeros);
    zeros = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (ev_ready) break;
      zeros++;
    end
  endtask

  initial begin : watchdog
    #100000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : main
    int zc;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values and clear length.
    @(negedge clk);
    chk("rst_cmp_valid", cmp_valid, 0);
    chk("rst_cmp_ctx_in", cmp_ctx_in, 0);
    chk("rst_cmp_flow_id", cmp_flow_id, 0);
    chk("rst_cmp_ev_data", cmp_ev_data, 0);
    chk("rst_done_cnt", ev_done_cnt, 0);
    zc = 0;
    for (int t = 0; t < 40; t++) begin
      if (ev_ready) break;
      zc++;
      @(negedge clk);
    end
    chk("clear_cycles", zc, 16);

    // First event sees cleared context.
    send_ev(4'd3, $urandom);
    @(negedge clk);
    chk("first_ev_valid", cmp_valid, 1);
    chk("first_ev_ctx", cmp_ctx_in, 0);
    idle();

    // Single event after init.
    send_init(4'd5, 16'hA5);
    send_ev(4'd5, $urandom);
    @(negedge clk);
    chk("single_ctx_a5", cmp_ctx_in, 16'hA5);
    send_ev(4'd5, $urandom);
    @(negedge clk);
    chk("single_ctx_a6", cmp_ctx_in, 16'hA6);
    idle();

    // Back-to-back events on one flow exercise forwarding.
    for (int i = 0; i < 4; i++) begin
      send_ev(4'd7, $urandom);
      @(negedge clk);
      chk("b2b_valid", cmp_valid, 1);
      chk("b2b_ctx", cmp_ctx_in, i);
    end
    idle();
    @(negedge clk);
    chk("b2b_done_cnt", ev_done_cnt, 7);

    // Init and event collide: init wins, event follows.
    init_valid = 1'b1; init_flow_id = 4'd2; init_ctx = 16'h55;
    ev_valid = 1'b1; ev_flow_id = 4'd2; ev_data = $urandom;
    #1;
    chk("coll_ev_ready", ev_ready, 0);
    chk("coll_init_ready", init_ready, 1);
    @(posedge clk); #1 init_valid = 1'b0;
    @(negedge clk);
    chk("coll_init_not_cmp", cmp_valid, 0);
    chk("coll_ev_ready_next", ev_ready, 1);
    @(posedge clk); #1 ev_valid = 1'b0;
    @(negedge clk);
    chk("coll_ev_valid", cmp_valid, 1);
    chk("coll_ev_ctx", cmp_ctx_in, 16'h55);

    // Interleaved flows, no bubbles.
    send_init(4'd1, 16'h0);
    send_init(4'd2, 16'h0);
    for (int i = 0; i < 10; i++) begin
      send_ev((i % 2) ? 4'd2 : 4'd1, $urandom);
      @(negedge clk);
      chk("ilv_valid", cmp_valid, 1);
    end
    send_ev(4'd1, $urandom);
    @(negedge clk);
    chk("ilv_flow1_end", cmp_ctx_in, 5);
    send_ev(4'd2, $urandom);
    @(negedge clk);
    chk("ilv_flow2_end", cmp_ctx_in, 5);
    idle();

    // Random traffic with a data-dependent update.
    repeat (2) @(posedge clk);
    #1 f_mode = 1'b1;
    for (int c = 0; c < 400; c++) begin
      ev_valid     = ($urandom_range(0, 3) != 0);
      ev_flow_id   = $urandom_range(0, 1) ? FW'($urandom_range(0, 3)) : FW'($urandom_range(0, 15));
      ev_data      = $urandom;
      init_valid   = ($urandom_range(0, 4) == 0);
      init_flow_id = FW'($urandom_range(0, 3));
      init_ctx     = CW'($urandom);
      @(posedge clk); #1;
    end
    idle();
    repeat (3) @(posedge clk);
    #1 f_mode = 1'b0;

    // Reset while an event for flow 9 sits in stage B.
    send_ev(4'd9, $urandom);
    rst = 1'b1;
    ev_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_done_cnt", ev_done_cnt, 0);
    chk("midrst_cmp_valid", cmp_valid, 0);
    wait_run(zc);
    chk("midrst_clear_cycles", zc, 15);
    send_ev(4'd9, $urandom);
    @(negedge clk);
    chk("midrst_flow9_ctx", cmp_ctx_in, 0);
    idle();
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
